// File: rtl/scan_ctrl.sv
// scan_ctrl: frame scan sequencer that steps an external pixel counter line by line.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module scan_ctrl #(
    parameter int LINE_LEN  = 1024,
    parameter int NUM_LINES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       pix_ready_i,
    input  logic [9:0] count_i,
    output logic       cnt_clear_o,
    output logic       cnt_enable_o,
    output logic       pix_valid_o,
    output logic [9:0] line_idx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CLEAR    = 3'd1;
    localparam logic [2:0] c_RUN      = 3'd2;
    localparam logic [2:0] c_LINE_END = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    localparam logic [9:0] c_LAST_PIX  = 10'(LINE_LEN - 1);
    localparam logic [9:0] c_LAST_LINE = 10'(NUM_LINES - 1);

    logic [2:0] state_q, state_d;
    logic [9:0] line_q, line_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            line_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

    // Abort wins over every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        case (state_q)
            c_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = c_CLEAR;
                    line_d  = 10'd0;
                end
            end
            c_CLEAR: begin
                state_d = abort_i ? c_IDLE : c_RUN;
            end
            c_RUN: begin
                if (abort_i) begin
                    state_d = c_IDLE;
                end else if (pix_ready_i && (count_i == c_LAST_PIX)) begin
                    state_d = c_LINE_END;
                end
            end
            c_LINE_END: begin
                if (abort_i) begin
                    state_d = c_IDLE;
                end else if (line_q == c_LAST_LINE) begin
                    state_d = c_DONE;
                end else begin
                    line_d  = line_q + 10'd1;
                    state_d = c_RUN;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // An abort cycle clears the counter and suppresses enable and done.
    always_comb begin
        cnt_clear_o  = 1'b0;
        cnt_enable_o = 1'b0;
        pix_valid_o  = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state_q != c_IDLE);
        case (state_q)
            c_CLEAR: begin
                cnt_clear_o = 1'b1;
            end
            c_RUN: begin
                pix_valid_o  = 1'b1;
                cnt_clear_o  = abort_i;
                cnt_enable_o = pix_ready_i && !abort_i;
            end
            c_LINE_END: begin
                cnt_clear_o = 1'b1;
            end
            c_DONE: begin
                cnt_clear_o = abort_i;
                done_o      = !abort_i;
            end
            default: begin
                cnt_clear_o = 1'b0;
            end
        endcase
    end

    assign line_idx_o = line_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: scoreboard bench for scan_ctrl with directed and random stimulus.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_scan_ctrl;

    localparam int LL = 4;
    localparam int NL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, abort = 1'b0, pix_ready = 1'b0;
    logic [9:0] count;
    logic       cnt_clear, cnt_enable, pix_valid, busy, done;
    logic [9:0] line_idx;

    logic       start2 = 1'b0;
    logic [9:0] count2;
    logic       cnt_clear2, cnt_enable2, pix_valid2, busy2, done2;
    logic [9:0] line_idx2;

    always #5 clk = ~clk;

    scan_ctrl #(.LINE_LEN(LL), .NUM_LINES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .pix_ready_i(pix_ready), .count_i(count),
        .cnt_clear_o(cnt_clear), .cnt_enable_o(cnt_enable), .pix_valid_o(pix_valid),
        .line_idx_o(line_idx), .busy_o(busy), .done_o(done)
    );

    scan_ctrl #(.NUM_LINES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(1'b0),
        .pix_ready_i(1'b1), .count_i(count2),
        .cnt_clear_o(cnt_clear2), .cnt_enable_o(cnt_enable2), .pix_valid_o(pix_valid2),
        .line_idx_o(line_idx2), .busy_o(busy2), .done_o(done2)
    );

    // Downstream pixel counters driven by the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 10'd0;
            count2 <= 10'd0;
        end else begin
            if (cnt_clear)       count <= 10'd0;
            else if (cnt_enable) count <= count + 10'd1;
            if (cnt_clear2)       count2 <= 10'd0;
            else if (cnt_enable2) count2 <= count2 + 10'd1;
        end
    end

    typedef struct {
        bit is_done;
        int line;
        int pix;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    bit   model_busy = 1'b0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the ordered list of (line, pixel) acceptances then done.
    task automatic drive(input bit st, input bit ab, input bit pr);
        bit was_busy;
        was_busy = model_busy;
        if (ab && was_busy) begin
            q.delete();
            model_busy = 1'b0;
        end
        if (st && !ab && !was_busy) begin
            for (int l = 0; l < NL; l++)
                for (int p = 0; p < LL; p++)
                    q.push_back('{is_done: 1'b0, line: l, pix: p});
            q.push_back('{is_done: 1'b1, line: 0, pix: 0});
            model_busy = 1'b1;
        end
        start     = st;
        abort     = ab;
        pix_ready = pr;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("clr_en_exclusive", {31'd0, cnt_clear & cnt_enable}, 32'd0);
            if (cnt_enable) begin
                check("en_needs_ready", {31'd0, pix_ready}, 32'd1);
                if (q.size() == 0) begin
                    check("pix_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("pix_kind", {31'd0, mon_e.is_done}, 32'd0);
                    check("pix_line", {22'd0, line_idx}, mon_e.line);
                    check("pix_count", {22'd0, count}, mon_e.pix);
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("done_kind", {31'd0, mon_e.is_done}, 32'd1);
                    model_busy = 1'b0;
                end
            end
        end
    end

    int n_acc2 = 0, n_done2 = 0, nb2 = 0, max2 = 0, cnt_at_done2 = -1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid2 && cnt_enable2) begin
                n_acc2++;
                if (int'(count2) > max2) max2 = int'(count2);
            end
            if (done2) begin
                n_done2++;
                cnt_at_done2 = int'(count2);
            end
            if (busy2) nb2++;
        end
    end

    // Runs one frame on the small instance; cycle index 0 is the CLEAR cycle.
    task automatic frame(input int stall_at, input int stall_len, input int abort_at,
                         input int restart_at, output int nbusy);
        bit stalled;
        @(posedge clk); #1 drive(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        nbusy = 0;
        for (int i = 0; i < 300; i++) begin
            stalled = (i >= stall_at) && (i < stall_at + stall_len);
            drive(i == restart_at, i == abort_at, !stalled);
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (i == 0 && abort_at != 0) begin
                check("lat_clear", {31'd0, cnt_clear}, 32'd1);
                check("lat_noval", {31'd0, pix_valid}, 32'd0);
            end
            if (i == 1 && abort_at > 1) check("lat_valid", {31'd0, pix_valid}, 32'd1);
            if (stalled) begin
                check("stall_en", {31'd0, cnt_enable}, 32'd0);
                check("stall_count", {22'd0, count}, 32'd2);
            end
            if (i == abort_at) begin
                check("abort_clear", {31'd0, cnt_clear}, 32'd1);
                check("abort_noen", {31'd0, cnt_enable}, 32'd0);
                check("abort_nodone", {31'd0, done}, 32'd0);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int nb;
        #1 rst_n = 1'b0;
        #2;
        check("rst_outputs", {22'd0, cnt_clear, cnt_enable, pix_valid, busy, done, 5'd0}, 32'd0);
        check("rst_line", {22'd0, line_idx}, 32'd0);
        check("rst_busy2", {31'd0, busy2}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        frame(1000, 0, -1, -1, nb);
        check("frame_cycles", nb, 32'd12);

        frame(3, 3, -1, -1, nb);
        check("stall_frame_cycles", nb, 32'd15);

        frame(1000, 0, 7, -1, nb);
        check("abort_cycles", nb, 32'd8);
        frame(1000, 0, -1, -1, nb);
        check("after_abort_cycles", nb, 32'd12);

        @(posedge clk); #1 drive(1'b1, 1'b1, 1'b1);
        @(posedge clk); #1 drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("start_abort_idle", {31'd0, busy}, 32'd0);

        frame(1000, 0, -1, 3, nb);
        check("restart_ignored_cycles", nb, 32'd12);

        @(posedge clk); #1 drive(1'b1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {22'd0, cnt_clear, cnt_enable, pix_valid, busy, done, 5'd0}, 32'd0);
        check("async_rst_line", {22'd0, line_idx}, 32'd0);
        q.delete();
        model_busy = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1
            drive(($urandom % 6) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0);
        end
        @(posedge clk); #1 drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 200 && model_busy; i++) @(negedge clk);
        @(negedge clk);
        check("drain_queue", q.size(), 32'd0);
        check("drain_idle", {31'd0, busy}, 32'd0);

        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 1200 && n_done2 == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("big_done_once", n_done2, 32'd1);
        check("big_max_count", max2, 32'd1023);
        check("big_accepts", n_acc2, 32'd1024);
        check("big_wrap_zero", cnt_at_done2, 32'd0);
        check("big_busy_cycles", nb2, 32'd1027);
        check("big_line", {22'd0, line_idx2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter LINE_LEN, default 1024, pixels per line; legal range 2..1024.
REQ-002 Parameter NUM_LINES, default 1024, lines per frame; legal range 1..1024.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-005 start  input  1  one-cycle request to begin a frame scan; sampled only in IDLE.
REQ-006 abort  input  1  stops the scan and returns the block to IDLE.
REQ-007 pix_ready  input  1  downstream accepts the current pixel this cycle.
REQ-008 count  input  10  current pixel count from the downstream 10-bit pixel counter.
REQ-009 cnt_clear  output  1  clear strobe to the pixel counter.
REQ-010 cnt_enable  output  1  increment strobe to the pixel counter.
REQ-011 pix_valid  output  1  a pixel at position count, line line_idx, is presented.
REQ-012 line_idx  output  10  current line number, 0..NUM_LINES-1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, RUN, LINE_END and DONE, held in a state register.
REQ-016 IDLE: all strobes low; start=1 and abort=0 -> CLEAR next cycle; line_idx set to 0 on this transition.
REQ-017 CLEAR: cnt_clear=1 for exactly one cycle -> RUN.
REQ-018 RUN: pix_valid=1; cnt_enable = pix_ready (combinational); pix_ready=0 holds state and count (stall).
REQ-019 RUN with pix_ready=1 and count==LINE_LEN-1 -> LINE_END; cnt_enable is still asserted that cycle.
REQ-020 LINE_END: cnt_clear=1, cnt_enable=0, pix_valid=0 for one cycle; line_idx==NUM_LINES-1 -> DONE, else line_idx increments by 1 and the next state is RUN.
REQ-021 DONE: done=1 for one cycle, line_idx holds its final value -> IDLE.
REQ-022 abort=1 in any non-IDLE state -> IDLE next cycle, with cnt_clear=1 during the abort cycle; done is not asserted.
REQ-023 abort has priority over start and over all RUN and LINE_END transitions in the same cycle.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 cnt_clear and cnt_enable SHALL never be high in the same cycle.
REQ-026 Latency: start at edge N -> cnt_clear high after edge N+1 -> first pix_valid after edge N+2.
REQ-027 A stall-free frame SHALL take exactly NUM_LINES*(LINE_LEN+1)+2 cycles from leaving IDLE to re-entering IDLE.
REQ-028 line_idx arithmetic is unsigned 10-bit and never exceeds NUM_LINES-1.
REQ-029 count values above LINE_LEN-1 in RUN are treated as not-last, with no error state.

Reset
REQ-030 reset low -> state IDLE and line_idx=0, with cnt_clear, cnt_enable, pix_valid, busy and done all 0, asynchronously.
REQ-031 Reset asserted mid-scan SHALL abandon the frame without a done pulse; after release the block waits in IDLE for start.
REQ-032 After reset is released, the first state change occurs on a clk edge, not on the reset edge.

Verification
REQ-033 LINE_LEN=4, NUM_LINES=2, pix_ready=1, start pulse -> sequence CLEAR, RUN x4, LINE_END, RUN x4, LINE_END, DONE; done high one cycle; 12 busy cycles.
REQ-034 Same configuration, pix_ready low for 3 cycles at count=2 -> count holds at 2, cnt_enable=0 for those 3 cycles; frame ends 3 cycles later than in REQ-033.
REQ-035 abort at line_idx=1, count=1 -> cnt_clear=1 that cycle, IDLE next, done never asserted; a new start then runs a full frame.
REQ-036 start and abort asserted together in IDLE -> remains in IDLE; start pulsed during RUN -> no effect on the sequence.
REQ-037 reset driven low between clock edges in RUN -> all outputs 0 before the next edge; state IDLE.
REQ-038 Defaults LINE_LEN=1024, NUM_LINES=1 with counter attached -> count reaches 1023 and then wraps to 0 as LINE_END clears; done asserted once.
